hamming_frame_tx: RTL and testbench
===================================

# hamming_frame_tx

Serial framing transmitter that sits directly downstream of the Hamming(7,4) encode/error-injection stage. It accepts one 7-bit codeword (4 message bits plus 3 parity bits, possibly error-injected) through a valid/ready handshake. It then shifts the codeword out LSB-first on a single line inside a start/stop frame, so a remote decoder board can receive it. It also keeps a wrapping count of completed frames for on-board display.

## Interface
- N, default 4, number of message bits.
- M, default 3, number of parity bits; codeword width is N+M.
- CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range is ≥2.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- codeword_in  input  N+M  codeword to send; bit 0 is sent first.
- codeword_valid  input  1  codeword_in is valid this cycle.
- codeword_ready  output  1  block can accept a codeword this cycle.
- tx  output  1  serial line; idles high; registered.
- busy  output  1  a frame is in progress.
- frames_sent  output  8  count of completed frames; wraps 255→0.

## Operation
- Frame format: 1 start bit (0), then N+M data bits with codeword bit 0 first, then 1 stop bit (1). With defaults this is 9 bits.
- States:
  - IDLE: tx=1, codeword_ready=1, busy=0. On codeword_valid && codeword_ready, load the shift register from codeword_in and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles, then shift right. After N+M bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then increment frames_sent and go to IDLE.
- Handshake:
  - codeword_ready = (state == IDLE). It is combinational from the state register only and never depends on codeword_valid.
  - codeword_valid while not ready is ignored. No buffering, no error.
  - codeword_in is sampled only on the accept edge. Later changes do not affect the frame in flight.
- busy = (state != IDLE).
- Counter widths:
  - bit-period counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - bit index counter is $clog2(N+M) bits.
- frames_sent increments exactly once per frame, on the edge that leaves STOP. It is 8-bit modular, so 8'hFF+1 = 8'h00.
- Reset:
  - Asserting rst_n low at any time, including mid-frame, immediately forces IDLE, tx=1, busy=0 and frames_sent=0.
  - The partial frame is abandoned and not counted.
  - codeword_valid is ignored while rst_n is low.

## Timing
- Reset values: tx=1, codeword_ready=1, busy=0, frames_sent=0.
- Accept occurs on edge k. tx falls to 0 immediately after edge k.
- Data bit i occupies the cycles after edges k+(1+i)·C through k+(2+i)·C−1, where C = CLKS_PER_BIT.
- The stop bit ends at edge k+(N+M+2)·C. At that edge, state returns to IDLE and frames_sent updates.
- codeword_ready is high in the cycle after edge k+(N+M+2)·C.
- Back-to-back: with valid held high, the minimum accept-to-accept spacing is (N+M+2)·C+1 cycles, which is 145 with defaults. tx stays 1 for exactly that single IDLE cycle.
- A valid that rises in the same cycle STOP completes is not accepted until the following IDLE cycle.

## Structure
- Shared package hamming_pkg holds:
  - N and M defaults;
  - enum tx_state_t {IDLE, START, DATA, STOP};
  - constants START_BIT=1'b0 and STOP_BIT=1'b1.
- One sub-module: bit_timer. It is parameterised by CLKS_PER_BIT, has inputs clk, rst_n and clear, and outputs a one-cycle bit_done pulse on the last cycle of each bit period.
- FSM, shift register, bit index and frame counter all live in hamming_frame_tx.

## Test plan
- Idle after reset: with rst_n released and no valid for 50 cycles, expect tx=1, codeword_ready=1, busy=0 and frames_sent=0 on every cycle.
- Single frame: with CLKS_PER_BIT=4, send codeword_in=7'b1010011 for one accept cycle.
  - Expect tx sequence 0,1,1,0,0,1,0,1,1, each value held for 4 cycles.
  - Expect frames_sent=1 afterward and busy high for exactly 36 cycles.
- Ignored input: change codeword_in to 7'h7F mid-frame and pulse valid while busy. The frame bits must be unchanged and codeword_ready must stay low throughout.
- Back-to-back: hold valid with codewords 7'h00 then 7'h7F. Expect accepts exactly 37 cycles apart (C=4), a single tx=1 idle cycle between stop and start, and frames_sent=2.
- Reset mid-frame: pull rst_n low during data bit 3. Expect tx=1 and busy=0 asynchronously, frames_sent=0, and a correct full frame on the next accept.
- Counter wrap: send 256 frames and expect frames_sent to read 0, then 1 after the 257th frame.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) serial framing path.
package hamming_pkg;

    // Default codeword split: message bits and parity bits.
    localparam int N_DEFAULT = 4;
    localparam int M_DEFAULT = 3;

    // Frame transmitter states.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Line levels for the frame delimiters.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : hamming_pkg

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// every bit period. Held at zero while clear is asserted so that the first
// period after a frame starts is always full length.
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Period counter: restart on clear, wrap after the last cycle of a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_done = !clear && (cnt == LAST);

endmodule : bit_timer

// File: rtl/hamming_frame_tx.sv
// Serial framing transmitter for Hamming codewords. Accepts one codeword
// through valid/ready, sends it LSB-first between a start bit (0) and a stop
// bit (1), and counts completed frames modulo 256.
module hamming_frame_tx
    import hamming_pkg::*;
#(
    parameter int N            = N_DEFAULT,
    parameter int M            = M_DEFAULT,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N+M-1:0] codeword_in,
    input  logic           codeword_valid,
    output logic           codeword_ready,
    output logic           tx,
    output logic           busy,
    output logic [7:0]     frames_sent
);

    localparam int            W        = N + M;
    localparam int            IW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    tx_state_t       state, state_d;
    logic [W-1:0]    shift_reg, shift_d;
    logic [IW-1:0]   bit_idx, idx_d;
    logic [7:0]      frames_d;
    logic            tx_d;
    logic            bit_done;

    // The timer runs only while a frame is on the line.
    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == IDLE),
        .bit_done (bit_done)
    );

    assign codeword_ready = (state == IDLE);
    assign busy           = (state != IDLE);

    // Next-state logic: frame sequencing, shift register load/shift, counters.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d  = state;
        shift_d  = shift_reg;
        idx_d    = bit_idx;
        frames_d = frames_sent;

        case (state)
            IDLE: begin
                if (codeword_valid && codeword_ready) begin
                    state_d = START;
                    shift_d = codeword_in;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_reg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = bit_idx + IW'(1);
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d  = IDLE;
                    frames_d = frames_sent + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is derived from the upcoming state so tx is registered
        // and changes on the same edge as the state.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            default: tx_d = STOP_BIT;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled before the edge.
        // The shift register is reset too: it is a few flops, not a memory,
        // and a known value keeps tx derivation deterministic.
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_idx     <= '0;
            frames_sent <= 8'd0;
            tx          <= STOP_BIT;
        end else begin
            state       <= state_d;
            shift_reg   <= shift_d;
            bit_idx     <= idx_d;
            frames_sent <= frames_d;
            tx          <= tx_d;
        end
    end

endmodule : hamming_frame_tx

// File: tb/tb_hamming_frame_tx.sv
// Scoreboard bench for hamming_frame_tx: the driver pushes each accepted
// codeword, a monitor decodes every frame seen on tx and compares it with a
// bit-level frame model built from the codeword.
module tb_hamming_frame_tx;
    import hamming_pkg::*;

    localparam int C         = 4;
    localparam int W         = N_DEFAULT + M_DEFAULT;
    localparam int FRAME_CYC = (W + 2) * C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] codeword_in = '0;
    logic         codeword_valid = 1'b0;
    logic         codeword_ready;
    logic         tx;
    logic         busy;
    logic [7:0]   frames_sent;

    hamming_frame_tx #(
        .N            (N_DEFAULT),
        .M            (M_DEFAULT),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .codeword_in    (codeword_in),
        .codeword_valid (codeword_valid),
        .codeword_ready (codeword_ready),
        .tx             (tx),
        .busy           (busy),
        .frames_sent    (frames_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] cw;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Offer a codeword and wait (bounded) for it to be accepted. With hold
    // set, valid stays high afterwards for a back-to-back follow-up.
    task automatic send(input logic [W-1:0] cw, input bit hold, output int acc);
        int n;
        @(negedge clk);
        codeword_in    = cw;
        codeword_valid = 1'b1;
        n = 0;
        while (!codeword_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!codeword_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            codeword_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            sb.push_back('{cw: cw, acc_cyc: acc});
            if (!hold) codeword_valid = 1'b0;
        end
    endtask

    // Wait (bounded) until all expected frames have been seen and the line is idle.
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || busy) && n < 2000);
        if (sb.size() != 0 || busy) check("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: decode each frame from its falling start edge and compare
    // every cycle against the expected frame pattern.
    initial begin
        forever begin
            exp_t           e;
            logic [W+1:0]   frame_bits;
            int             bad_bits;
            int             bad_hs;
            bit             aborted;
            @(negedge clk);
            if (!rst_n) begin
                exp_frames = 0;
                continue;
            end
            if (tx === 1'b0) begin
                bad_bits = 0;
                bad_hs   = 0;
                aborted  = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    e.cw      = '0;
                    e.acc_cyc = cyc;
                end else begin
                    e = sb.pop_front();
                end
                check("start_latency", cyc, e.acc_cyc);
                // Bit 0 of the frame is the start bit, then the codeword LSB first, then stop.
                frame_bits = {STOP_BIT, e.cw, START_BIT};
                for (int j = 0; j < FRAME_CYC; j++) begin
                    if (j > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== frame_bits[j / C]) bad_bits++;
                    if (busy !== 1'b1 || codeword_ready !== 1'b0) bad_hs++;
                end
                if (aborted) begin
                    exp_frames = 0;
                    continue;
                end
                check("frame_bit_errors", bad_bits, 0);
                check("frame_busy_ready_errors", bad_hs, 0);
                @(negedge clk);
                if (!rst_n) begin
                    exp_frames = 0;
                    continue;
                end
                exp_frames = (exp_frames + 1) % 256;
                check("end_tx", tx, 1);
                check("end_ready", codeword_ready, 1);
                check("end_busy", busy, 0);
                check("end_frames_sent", frames_sent, exp_frames);
            end
        end
    end

    initial begin
        int a1, a2, acc;
        logic [W-1:0] cw;

        // Reset state, with a valid pulse that must be ignored.
        codeword_valid = 1'b1;
        codeword_in    = 7'h55;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", codeword_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_frames", frames_sent, 0);
        codeword_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for 50 cycles.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx", tx, 1);
            check("idle_ready", codeword_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_frames", frames_sent, 0);
        end

        // Single frame.
        send(7'b1010011, 1'b0, acc);
        wait_idle();
        check("single_frames_sent", frames_sent, 1);

        // Input changes and a valid pulse during a frame must be ignored.
        send(7'h2A, 1'b0, acc);
        repeat (10) @(negedge clk);
        codeword_in    = 7'h7F;
        codeword_valid = 1'b1;
        check("ignored_ready_low", codeword_ready, 0);
        @(negedge clk);
        codeword_valid = 1'b0;
        wait_idle();
        check("ignored_frames_sent", frames_sent, 2);

        // Back-to-back with valid held high.
        send(7'h00, 1'b1, a1);
        send(7'h7F, 1'b0, a2);
        check("b2b_spacing", a2 - a1, FRAME_CYC + 1);
        wait_idle();
        check("b2b_frames_sent", frames_sent, 4);

        // Random codewords with random gaps and occasional back-to-back.
        for (int i = 0; i < 12; i++) begin
            cw = W'($urandom);
            send(cw, 1'($urandom_range(0, 1)), acc);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        codeword_valid = 1'b0;
        wait_idle();
        check("random_frames_sent", frames_sent, 16);

        // Reset during data bit 3.
        send(W'($urandom), 1'b0, acc);
        repeat (4 * C + 2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_frames", frames_sent, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(W'($urandom), 1'b0, acc);
        wait_idle();
        check("post_rst_frames_sent", frames_sent, 1);

        // Counter wrap: fresh reset, 256 frames, then one more.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(W'($urandom), (i != 255), acc);
        end
        wait_idle();
        check("wrap_frames_sent_0", frames_sent, 0);
        send(W'($urandom), 1'b0, acc);
        wait_idle();
        check("wrap_frames_sent_1", frames_sent, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hamming_frame_tx
